// File: rtl/music_seq_ctrl.sv
// -----------------------------------------------------------------------------
// music_seq_ctrl
//
// Song sequencer for the buzzer. Walks an external synchronous-read song ROM,
// plays each note for a whole number of beats, leaves a short silent gap
// between notes and supports play/pause/stop from the debounced buttons.
//
// ROM word layout: [7:3] note code (0 = rest, 31 = end marker)
//                  [2:0] duration in beats minus one
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-high
//   i_play_pulse  one-cycle pulse: start from idle, or toggle pause/resume
//   i_stop_pulse  one-cycle pulse: abort and return to the start of the song
//   i_loop_en     1 = restart at address 0 after the end of the song
//   o_rom_addr    song ROM address (always the current address)
//   i_rom_data    song ROM word, valid one cycle after o_rom_addr
//   o_tone_code   note code for the tone generator
//   o_tone_en     tone generator enable
//   o_playing     high while fetching, loading, playing or in a gap
//   o_paused      high while paused
//   o_note_index  address of the note being played, for the display
// -----------------------------------------------------------------------------
module music_seq_ctrl #(
  parameter int TICKS_PER_BEAT = 6_250_000,
  parameter int GAP_TICKS      = 500_000,
  parameter int ROM_AW         = 6,
  parameter int SONG_LEN       = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_play_pulse,
  input  logic              i_stop_pulse,
  input  logic              i_loop_en,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic [4:0]        o_tone_code,
  output logic              o_tone_en,
  output logic              o_playing,
  output logic              o_paused,
  output logic [ROM_AW-1:0] o_note_index
);

  localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICKS_PER_BEAT - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_TICKS - 1);
  // One bit wider than the address so SONG_LEN = 2^ROM_AW is representable.
  localparam logic [ROM_AW:0]   SONG_END  = (ROM_AW+1)'(SONG_LEN);
  localparam logic [ROM_AW:0]   ADDR_ONE  = (ROM_AW+1)'(1);
  localparam logic [4:0]        CODE_END  = 5'd31;
  localparam logic [4:0]        CODE_REST = 5'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_PAUSED
  } state_t;

  state_t              r_state, w_state_next;
  state_t              r_resume, w_resume_next;
  state_t              w_song_end_state;
  logic [ROM_AW-1:0]   r_addr, w_addr_next;
  logic [ROM_AW-1:0]   r_note_index, w_note_index_next;
  logic [ROM_AW:0]     w_addr_inc;
  logic [TW-1:0]       r_tick, w_tick_next;
  logic [GW-1:0]       r_gap, w_gap_next;
  logic [2:0]          r_beat, w_beat_next;
  logic [2:0]          r_dur, w_dur_next;
  logic [4:0]          r_tone_code, w_tone_code_next;
  logic [4:0]          w_rom_code;
  logic [2:0]          w_rom_dur;

  assign w_rom_code = i_rom_data[7:3];
  assign w_rom_dur  = i_rom_data[2:0];
  assign w_addr_inc = {1'b0, r_addr} + ADDR_ONE;

  // Where to go once the song is exhausted (end marker or SONG_LEN reached).
  assign w_song_end_state = i_loop_en ? S_FETCH : S_IDLE;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first so that no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_next      = r_state;
    w_resume_next     = r_resume;
    w_addr_next       = r_addr;
    w_note_index_next = r_note_index;
    w_tick_next       = r_tick;
    w_gap_next        = r_gap;
    w_beat_next       = r_beat;
    w_dur_next        = r_dur;
    w_tone_code_next  = r_tone_code;

    case (r_state)
      S_IDLE: begin
        if (i_play_pulse) begin
          w_addr_next  = '0;
          w_state_next = S_FETCH;
        end
      end

      // The ROM registers the address during this cycle.
      S_FETCH: begin
        w_state_next = S_LOAD;
      end

      S_LOAD: begin
        if (w_rom_code == CODE_END) begin
          w_addr_next  = '0;
          w_state_next = w_song_end_state;
        end else begin
          w_tone_code_next  = w_rom_code;
          w_dur_next        = w_rom_dur;
          w_tick_next       = '0;
          w_beat_next       = '0;
          w_gap_next        = '0;
          w_note_index_next = r_addr;
          w_state_next      = S_PLAY;
        end
      end

      S_PLAY: begin
        if (r_tick == TICK_LAST) begin
          w_tick_next = '0;
          if (r_beat == r_dur) begin
            w_gap_next   = '0;
            w_state_next = S_GAP;
          end else begin
            w_beat_next = r_beat + 3'd1;
          end
        end else begin
          w_tick_next = r_tick + TW'(1);
        end
        // The cycle carrying the pulse still counts as played time; pausing
        // parks whichever state the counters have just advanced into.
        if (i_play_pulse) begin
          w_resume_next = w_state_next;
          w_state_next  = S_PAUSED;
        end
      end

      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_gap_next = '0;
          if (w_addr_inc == SONG_END) begin
            w_addr_next  = '0;
            w_state_next = w_song_end_state;
          end else begin
            w_addr_next  = w_addr_inc[ROM_AW-1:0];
            w_state_next = S_FETCH;
          end
        end else begin
          w_gap_next = r_gap + GW'(1);
        end
        // Pausing a song that has just finished is meaningless; stay idle.
        if (i_play_pulse && (w_state_next != S_IDLE)) begin
          w_resume_next = w_state_next;
          w_state_next  = S_PAUSED;
        end
      end

      S_PAUSED: begin
        if (i_play_pulse) begin
          w_state_next = r_resume;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Stop overrides everything, including a simultaneous play pulse.
    if (i_stop_pulse) begin
      w_state_next      = S_IDLE;
      w_addr_next       = '0;
      w_tick_next       = '0;
      w_beat_next       = '0;
      w_gap_next        = '0;
      w_note_index_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_resume     <= S_IDLE;
      r_addr       <= '0;
      r_note_index <= '0;
      r_tick       <= '0;
      r_gap        <= '0;
      r_beat       <= '0;
      r_dur        <= '0;
      r_tone_code  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      r_state      <= w_state_next;
      r_resume     <= w_resume_next;
      r_addr       <= w_addr_next;
      r_note_index <= w_note_index_next;
      r_tick       <= w_tick_next;
      r_gap        <= w_gap_next;
      r_beat       <= w_beat_next;
      r_dur        <= w_dur_next;
      r_tone_code  <= w_tone_code_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state so reset clears them at once
  // ---------------------------------------------------------------------------
  assign o_rom_addr   = r_addr;
  assign o_note_index = r_note_index;
  assign o_tone_code  = r_tone_code;
  assign o_tone_en    = (r_state == S_PLAY) && (r_tone_code != CODE_REST);
  assign o_playing    = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                        (r_state == S_PLAY)  || (r_state == S_GAP);
  assign o_paused     = (r_state == S_PAUSED);

endmodule

// File: tb/tb_music_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_music_seq_ctrl
//
// Self-checking bench for music_seq_ctrl. A reference model expands the song
// ROM into a cycle-by-cycle timeline of expected outputs (fetch, load, beats,
// gap) and splices pause windows into it; the DUT is compared against that
// timeline every cycle. Directed scenarios add fixed-cycle expectations.
// -----------------------------------------------------------------------------
module tb_music_seq_ctrl;

  localparam int TPB  = 4;
  localparam int GAP  = 2;
  localparam int AW   = 6;
  localparam int SLEN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          play = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] note_index;
  logic [7:0]    rom_data;
  logic [4:0]    tone_code;
  logic          tone_en;
  logic          playing;
  logic          paused;

  logic [7:0]    rom [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read song ROM.
  always @(posedge clk) rom_data <= rom[rom_addr];

  music_seq_ctrl #(
    .TICKS_PER_BEAT(TPB),
    .GAP_TICKS     (GAP),
    .ROM_AW        (AW),
    .SONG_LEN      (SLEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_play_pulse(play),
    .i_stop_pulse(stop),
    .i_loop_en   (loop_en),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_tone_code (tone_code),
    .o_tone_en   (tone_en),
    .o_playing   (playing),
    .o_paused    (paused),
    .o_note_index(note_index)
  );

  // ---------------------------------------------------------------------------
  // Reference model: expected timeline
  // ---------------------------------------------------------------------------
  typedef enum {K_FETCH, K_LOAD, K_PLAY, K_GAP, K_PAUSE} kind_t;

  typedef struct {
    kind_t         kind;
    logic          en;
    logic [4:0]    code;
    logic [AW-1:0] idx;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          exp_q[$];
  int            pulse_q[$];
  int            model_idx = 0;

  logic          obs_en[$];
  logic          obs_play[$];
  logic          obs_pause[$];
  logic [4:0]    obs_code[$];
  logic [AW-1:0] obs_addr[$];
  logic [AW-1:0] obs_idx[$];

  function automatic exp_t mk(kind_t k, logic en, logic [4:0] c, int i, int a);
    exp_t e;
    e.kind = k;
    e.en   = en;
    e.code = c;
    e.idx  = AW'(i);
    e.addr = AW'(a);
    return e;
  endfunction

  // Expand the song: each word costs fetch+load, then (dur+1)*TPB sounding
  // cycles and GAP silent cycles; the song ends at the end marker or SONG_LEN.
  task automatic build_trace(input bit lp, input int max_cyc);
    int         a = 0;
    int         cur_idx = model_idx;
    logic [4:0] cur_code = 5'd0;
    logic [4:0] code;
    logic [2:0] dur;
    exp_q.delete();
    pulse_q.delete();
    while (exp_q.size() < max_cyc) begin
      exp_q.push_back(mk(K_FETCH, 1'b0, cur_code, cur_idx, a));
      exp_q.push_back(mk(K_LOAD,  1'b0, cur_code, cur_idx, a));
      code = rom[a][7:3];
      dur  = rom[a][2:0];
      if (code == 5'd31) begin
        if (lp) begin
          a = 0;
          continue;
        end
        break;
      end
      cur_code = code;
      cur_idx  = a;
      repeat ((int'(dur) + 1) * TPB)
        exp_q.push_back(mk(K_PLAY, code != 5'd0, cur_code, cur_idx, a));
      repeat (GAP)
        exp_q.push_back(mk(K_GAP, 1'b0, cur_code, cur_idx, a));
      a++;
      if (a == SLEN) begin
        if (lp) a = 0;
        else break;
      end
    end
    model_idx = cur_idx;
  endtask

  // Pulse during timeline cycle k, stay paused n cycles, pulse again on the
  // last paused cycle; everything after simply shifts by n.
  task automatic add_pause(input int k, input int n);
    exp_t p;
    p      = exp_q[k];
    p.kind = K_PAUSE;
    p.en   = 1'b0;
    for (int i = 0; i < n; i++) exp_q.insert(k + 1, p);
    pulse_q.push_back(k);
    pulse_q.push_back(k + n);
  endtask

  function automatic bit is_pulse(int t);
    foreach (pulse_q[i]) if (pulse_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic basic_en(int c);
    return ((c >= 3) && (c <= 14)) || ((c >= 19) && (c <= 26));
  endfunction

  task automatic load_rom(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3);
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
    rom[3] = w3;
  endtask

  // Start from idle with a play pulse and compare the DUT against the timeline
  // each cycle. Optional stop (with or without play) or async reset at a given
  // timeline index. Finishes with a few idle-state comparisons.
  task automatic run_trace(input int stop_idx, input bit stop_play, input int rst_idx);
    exp_t e;
    bit   aborted = 1'b0;
    obs_en.delete(); obs_play.delete(); obs_pause.delete();
    obs_code.delete(); obs_addr.delete(); obs_idx.delete();
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      e = exp_q[t];
      obs_en.push_back(tone_en);
      obs_play.push_back(playing);
      obs_pause.push_back(paused);
      obs_code.push_back(tone_code);
      obs_addr.push_back(rom_addr);
      obs_idx.push_back(note_index);
      checks++;
      if (tone_en !== e.en) begin
        errors++;
        $display("FAIL trace_tone_en t=%0d got %b want %b", t, tone_en, e.en);
      end
      checks++;
      if (playing !== (e.kind != K_PAUSE)) begin
        errors++;
        $display("FAIL trace_playing t=%0d got %b want %b", t, playing, e.kind != K_PAUSE);
      end
      checks++;
      if (paused !== (e.kind == K_PAUSE)) begin
        errors++;
        $display("FAIL trace_paused t=%0d got %b want %b", t, paused, e.kind == K_PAUSE);
      end
      checks++;
      if (rom_addr !== e.addr) begin
        errors++;
        $display("FAIL trace_rom_addr t=%0d got %0d want %0d", t, rom_addr, e.addr);
      end
      checks++;
      if (note_index !== e.idx) begin
        errors++;
        $display("FAIL trace_note_index t=%0d got %0d want %0d", t, note_index, e.idx);
      end
      if ((e.kind == K_PLAY) || (e.kind == K_PAUSE)) begin
        checks++;
        if (tone_code !== e.code) begin
          errors++;
          $display("FAIL trace_tone_code t=%0d got %0d want %0d", t, tone_code, e.code);
        end
      end
      if (t == rst_idx) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tone_en, playing, paused, note_index, rom_addr, tone_code} !== '0) begin
          errors++;
          $display("FAIL async_reset en=%b play=%b pause=%b idx=%0d addr=%0d code=%0d want all 0",
                   tone_en, playing, paused, note_index, rom_addr, tone_code);
        end
        @(negedge clk);
        rst       = 1'b0;
        model_idx = 0;
        aborted   = 1'b1;
        break;
      end
      play = is_pulse(t) || ((t == stop_idx) && stop_play);
      stop = (t == stop_idx);
      @(negedge clk);
      play = 1'b0;
      stop = 1'b0;
      if (t == stop_idx) begin
        model_idx = 0;
        aborted   = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tone_en, playing, paused} !== 3'b000) begin
        errors++;
        $display("FAIL idle_flags i=%0d got en=%b play=%b pause=%b want 000",
                 i, tone_en, playing, paused);
      end
      checks++;
      if (int'(rom_addr) >= SLEN) begin
        errors++;
        $display("FAIL idle_rom_addr_range got %0d want <%0d", rom_addr, SLEN);
      end
      checks++;
      if (note_index !== AW'(model_idx)) begin
        errors++;
        $display("FAIL idle_note_index got %0d want %0d", note_index, model_idx);
      end
      if (aborted) begin
        checks++;
        if (rom_addr !== '0) begin
          errors++;
          $display("FAIL abort_rom_addr got %0d want 0", rom_addr);
        end
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tone_en, playing, paused, note_index, rom_addr, tone_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs en=%b play=%b pause=%b idx=%0d addr=%0d code=%0d want all 0",
               tone_en, playing, paused, note_index, rom_addr, tone_code);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tone_en, playing, paused} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got %b want 000", {tone_en, playing, paused});
    end
  endtask

  task automatic test_basic();
    int k;
    load_rom(8'h0A, 8'h11, 8'h00, 8'hF8);
    loop_en = 1'b0;
    build_trace(1'b0, 400);
    run_trace(-1, 1'b0, -1);
    // Timeline index = cycle - 1 (cycle 0 carries the play pulse).
    for (int c = 1; c <= 38; c++) begin
      checks++;
      if (obs_en[c-1] !== basic_en(c)) begin
        errors++;
        $display("FAIL basic_tone_en cycle=%0d got %b want %b", c, obs_en[c-1], basic_en(c));
      end
    end
    for (int c = 3; c <= 26; c++) begin
      if (basic_en(c)) begin
        checks++;
        if (obs_code[c-1] !== ((c <= 14) ? 5'd1 : 5'd2)) begin
          errors++;
          $display("FAIL basic_tone_code cycle=%0d got %0d", c, obs_code[c-1]);
        end
      end
    end
    k = 0;
    for (int c = 31; c <= 34; c++) if (obs_play[c-1] === 1'b1) k++;
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL basic_rest_playing got %0d want 4", k);
    end
  endtask

  task automatic test_pause();
    int k;
    load_rom(8'h0A, 8'h11, 8'h00, 8'hF8);
    build_trace(1'b0, 400);
    add_pause(6, 20);
    run_trace(-1, 1'b0, -1);
    k = 0;
    for (int i = 7; i <= 26; i++) if ((obs_en[i] === 1'b0) && (obs_pause[i] === 1'b1)) k++;
    checks++;
    if (k != 20) begin
      errors++;
      $display("FAIL pause_window got %0d want 20", k);
    end
    k = 0;
    for (int i = 0; i <= 37; i++) if (obs_en[i] === 1'b1) k++;
    checks++;
    if (k != 12) begin
      errors++;
      $display("FAIL pause_note0_total got %0d want 12", k);
    end
  endtask

  task automatic test_loop();
    int k;
    load_rom(8'h0A, 8'h11, 8'h00, 8'hF8);
    loop_en = 1'b1;
    build_trace(1'b1, 100);
    run_trace(95, 1'b0, -1);
    loop_en = 1'b0;
    checks++;
    if ((obs_addr[38] !== '0) || (obs_play[38] !== 1'b1)) begin
      errors++;
      $display("FAIL loop_restart addr=%0d play=%b want 0 1", obs_addr[38], obs_play[38]);
    end
    checks++;
    if ((obs_idx[37] !== AW'(2)) || (obs_idx[40] !== '0)) begin
      errors++;
      $display("FAIL loop_note_index got %0d,%0d want 2,0", obs_idx[37], obs_idx[40]);
    end
    k = 0;
    for (int c = 1; c <= 38; c++) if (obs_en[38 + c - 1] !== basic_en(c)) k++;
    checks++;
    if (k != 0) begin
      errors++;
      $display("FAIL loop_repeat_pattern got %0d differing cycles want 0", k);
    end
    k = 0;
    for (int i = 0; i <= 95; i++) if (obs_play[i] !== 1'b1) k++;
    checks++;
    if (k != 0) begin
      errors++;
      $display("FAIL loop_no_idle got %0d non-playing cycles want 0", k);
    end
  endtask

  task automatic test_song_len();
    load_rom(8'h0A, 8'h11, 8'h19, 8'h21);
    for (int i = 4; i < 64; i++) rom[i] = 8'h5A;
    build_trace(1'b0, 400);
    run_trace(-1, 1'b0, -1);
    checks++;
    if (obs_addr[obs_addr.size()-1] !== AW'(3)) begin
      errors++;
      $display("FAIL song_len_last_addr got %0d want 3", obs_addr[obs_addr.size()-1]);
    end
  endtask

  task automatic test_stop_priority();
    load_rom(8'h0A, 8'h11, 8'h00, 8'hF8);
    build_trace(1'b0, 400);
    pulse_q.push_back(1);   // LOAD of note 0: ignored
    pulse_q.push_back(17);  // LOAD of note 1: ignored
    run_trace(-1, 1'b0, -1);
    build_trace(1'b0, 400);
    run_trace(5, 1'b1, -1);  // stop + play together mid note 0
  endtask

  task automatic test_reset_midnote();
    load_rom(8'h0A, 8'h11, 8'h19, 8'hF8);
    build_trace(1'b0, 400);
    run_trace(-1, 1'b0, 32);
    build_trace(1'b0, 400);
    run_trace(-1, 1'b0, -1);
    checks++;
    if ((obs_addr[0] !== '0) || (obs_idx[2] !== '0)) begin
      errors++;
      $display("FAIL reset_restart addr=%0d idx=%0d want 0 0", obs_addr[0], obs_idx[2]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      bit         lp;
      int         sz;
      int         start;
      int         k;
      int         loads[$];
      logic [4:0] c;
      logic [2:0] d;
      for (int a = 0; a < SLEN; a++) begin
        c = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
        d = 3'($urandom_range(0, 7));
        rom[a] = {c, d};
      end
      lp      = 1'($urandom_range(0, 1));
      loop_en = lp;
      build_trace(lp, 250);
      sz = exp_q.size();
      if (($urandom_range(0, 1) == 1) && (sz > 2)) begin
        start = $urandom_range(0, sz - 2);
        for (int j = 0; j < sz - 1; j++) begin
          k = (start + j) % (sz - 1);
          if (((exp_q[k].kind == K_PLAY) || (exp_q[k].kind == K_GAP)) &&
              (exp_q[k+1].kind == exp_q[k].kind)) begin
            add_pause(k, $urandom_range(1, 8));
            break;
          end
        end
      end
      foreach (exp_q[i]) if ((exp_q[i].kind == K_LOAD) && (i < exp_q.size() - 1)) loads.push_back(i);
      if (loads.size() > 0) pulse_q.push_back(loads[$urandom_range(0, loads.size() - 1)]);
      if (lp) run_trace(exp_q.size() - 1, 1'($urandom_range(0, 1)), -1);
      else    run_trace(-1, 1'b0, -1);
    end
    loop_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h5A;
    test_reset();
    test_basic();
    test_pause();
    test_loop();
    test_song_len();
    test_stop_priority();
    test_reset_midnote();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_seq_ctrl.md
Name: music_seq_ctrl

Overview:
- Sequencer that drives the buzzer tone generator from a song ROM: fetches note/duration words, times each note in beats, inserts inter-note gaps, handles play/pause/stop.
- Sits between the debounced music button logic and the tone generator. Exports the current note index for the 7-segment display scanner.
- The synchronous-read song ROM is external to this block.

Parameters:
- TICKS_PER_BEAT, 6_250_000, clk cycles per beat (125 ms at 50 MHz); must be ≥2.
- GAP_TICKS, 500_000, silent cycles between notes (10 ms); must be ≥1.
- ROM_AW, 6, song ROM address width.
- SONG_LEN, 48, number of ROM words played; must be ≥1 and ≤2^ROM_AW.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous reset, active-high
- play_pulse  in  1  one-cycle pulse from debounced music button; toggles play/pause
- stop_pulse  in  1  one-cycle pulse; abort and return to start
- loop_en  in  1  1 = restart at address 0 after the end of the song
- rom_addr  out  ROM_AW  song ROM address
- rom_data  in  8  ROM word, valid 1 cycle after rom_addr. [7:3] note code (0 = rest, 31 = end marker), [2:0] duration-1 in beats
- tone_code  out  5  note code to tone generator
- tone_en  out  1  tone generator enable
- playing  out  1  high in FETCH/LOAD/PLAY/GAP
- paused  out  1  high in PAUSED
- note_index  out  ROM_AW  address of the note being played, for display

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0. State is IDLE. Address, beat counter and tick counter are 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP, PAUSED.
- IDLE:
  - On play_pulse: address ← 0, go to FETCH.
  - tone_en = 0.
- FETCH (1 cycle): rom_addr = current address, go to LOAD.
- LOAD (1 cycle): rom_data is valid and is decoded.
  - If code = 31: end of song. With loop_en = 1, address ← 0 and go to FETCH. Otherwise go to IDLE.
  - Otherwise latch tone_code = code and dur = [2:0], clear the counters, note_index ← address, go to PLAY.
- PLAY:
  - Lasts exactly (dur+1)*TICKS_PER_BEAT cycles.
  - Tick counter wraps at TICKS_PER_BEAT-1 and increments the beat counter.
  - On the last tick of beat dur, go to GAP.
  - tone_en = 1 if tone_code ≠ 0, else 0. A rest is silent but timed identically.
- GAP:
  - Lasts exactly GAP_TICKS cycles with tone_en = 0.
  - On exit, address ← address+1.
  - If the new address = SONG_LEN, apply the end-of-song rule from LOAD. Otherwise go to FETCH.
- Pause:
  - play_pulse in PLAY or GAP → PAUSED. The interrupted state (PLAY/GAP) is saved and all counters freeze. tone_en = 0 and tone_code is held.
  - play_pulse in PAUSED returns to the saved state next cycle. Counting continues from the frozen values, so total audible time is unchanged.
  - play_pulse in FETCH or LOAD is ignored.
- stop_pulse in any state: next state is IDLE, address and counters are cleared, tone_en = 0, note_index = 0.
- Simultaneous stop_pulse and play_pulse: stop wins. A play_pulse that arrives in IDLE after a stop restarts from address 0.
- rom_addr holds the current address in every state. The sequencer never reads beyond SONG_LEN-1.
- Latency: play_pulse in IDLE → tone_en high 3 cycles later (IDLE→FETCH→LOAD→PLAY).
- Reset asserted mid-note: outputs clear immediately (asynchronously). The first play_pulse after release starts from note 0.

Test Plan:
- Bench parameters for all scenarios: TICKS_PER_BEAT=4, GAP_TICKS=2, SONG_LEN=4.
- Basic: ROM = {0x0A (code 1, 3 beats), 0x11 (code 2, 2 beats), 0x00 (rest, 1 beat), 0xF8 (end)}, loop_en=0, play_pulse at cycle 0.
  - tone_en high cycles 3–14 with tone_code=1.
  - Low 15–16 (gap), 17–18 (fetch/load).
  - High 19–26 with tone_code=2.
  - Rest note: tone_en low for 4 cycles; playing stays high.
  - After the end marker: IDLE, playing=0.
- Pause: play_pulse at cycle 7 (mid note 0) → PAUSED, tone_en=0 for 20 cycles. Second play_pulse → note 0 resumes. Total tone_en-high count for note 0 is still 12.
- Loop: loop_en=1 with the ROM from the Basic scenario → after the end marker, rom_addr=0 and note_index returns to 0. Same cycle pattern repeats with no IDLE visit.
- SONG_LEN boundary: ROM with no end marker, SONG_LEN=4, loop_en=0 → after note 3's gap, IDLE; rom_addr never reaches 4.
- Stop/priority:
  - stop_pulse and play_pulse in the same cycle during PLAY → IDLE, tone_en=0 next cycle, note_index=0.
  - play_pulse in LOAD → ignored; playback is uninterrupted.
- Reset: rst asserted during PLAY of note 2 → tone_en, playing and note_index go 0 immediately. After release plus one play_pulse, rom_addr=0.
